// File: rtl/temp_sample_averager.sv
// Block-averages XADC temperature samples and flags stale input.
// CLK/RST sync; sampleIn/sampleValid in; digitalTemp/ready/stale out.
module temp_sample_averager #(
  parameter int LOG2N   = 3,
  parameter int TIMEOUT = 200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [11:0] sampleIn,
  input  logic        sampleValid,
  output logic [11:0] digitalTemp,
  output logic        ready,
  output logic        stale
);

  localparam int ACCW = 12 + LOG2N;
  localparam int IW   = $clog2(TIMEOUT);

  localparam logic [LOG2N-1:0] CNT_LAST  = '1;
  localparam logic [IW-1:0]    IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    STALE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [ACCW-1:0]  acc, acc_d;
  logic [LOG2N-1:0] sampleCnt, cnt_d;
  logic [IW-1:0]    idleCnt, idle_d;
  logic [11:0]      temp_d;
  logic             ready_d;
  logic             stale_d;

  logic [ACCW-1:0]  sum;
  logic [11:0]      avg;

  // Sum of at most 2**LOG2N full-scale samples fits ACCW bits.
  assign sum = acc + ACCW'(sampleIn);
  assign avg = 12'(sum >> LOG2N);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= FILL;
      acc         <= '0;
      sampleCnt   <= '0;
      idleCnt     <= '0;
      digitalTemp <= '0;
      ready       <= 1'b0;
      stale       <= 1'b0;
    end else begin
      state       <= state_d;
      acc         <= acc_d;
      sampleCnt   <= cnt_d;
      idleCnt     <= idle_d;
      digitalTemp <= temp_d;
      ready       <= ready_d;
      stale       <= stale_d;
    end
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = sampleCnt;
    idle_d  = idleCnt;
    temp_d  = digitalTemp;
    ready_d = ready;
    stale_d = stale;
    unique case (state)
      FILL, RUN: begin
        if (sampleValid) begin
          // A sample always beats a watchdog expiry on the same cycle.
          idle_d = '0;
          if (sampleCnt == CNT_LAST) begin
            temp_d  = avg;
            acc_d   = '0;
            cnt_d   = '0;
            ready_d = 1'b1;
            state_d = RUN;
          end else begin
            acc_d = sum;
            cnt_d = sampleCnt + LOG2N'(1);
          end
        end else if (idleCnt == IDLE_LAST) begin
          // Partial window is discarded; digitalTemp keeps last value.
          state_d = STALE;
          stale_d = 1'b1;
          ready_d = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          idle_d  = '0;
        end else begin
          idle_d = idleCnt + IW'(1);
        end
      end
      STALE: begin
        if (sampleValid) begin
          state_d = FILL;
          stale_d = 1'b0;
          acc_d   = ACCW'(sampleIn);
          cnt_d   = LOG2N'(1);
          idle_d  = '0;
        end
      end
      default: begin
        state_d = FILL;
        acc_d   = '0;
        cnt_d   = '0;
        idle_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_temp_sample_averager.sv
// Randomized scoreboard bench for temp_sample_averager.
// Expected outputs are queued per cycle and checked by a monitor.
module tb_temp_sample_averager;

  localparam int LOG2N   = 3;
  localparam int N       = 1 << LOG2N;
  localparam int TIMEOUT = 200;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [11:0] sampleIn = '0;
  logic        sampleValid = 1'b0;
  logic [11:0] digitalTemp;
  logic        ready;
  logic        stale;

  temp_sample_averager #(
    .LOG2N(LOG2N),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .sampleIn(sampleIn),
    .sampleValid(sampleValid),
    .digitalTemp(digitalTemp),
    .ready(ready),
    .stale(stale)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int temp;
    bit rdy;
    bit stl;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: list of samples in the open window.
  int win[$];
  int mIdle = 0;
  bit mStale = 0;
  bit mRdy = 0;
  int mTemp = 0;

  task automatic model_step(bit r, bit v, int d);
    int s;
    if (r) begin
      win.delete();
      mIdle = 0; mStale = 0; mRdy = 0; mTemp = 0;
    end else if (mStale) begin
      if (v) begin
        mStale = 0;
        win.delete();
        win.push_back(d);
        mIdle = 0;
      end
    end else if (v) begin
      mIdle = 0;
      win.push_back(d);
      if (win.size() == N) begin
        s = 0;
        foreach (win[i]) s += win[i];
        mTemp = s / N;
        mRdy = 1;
        win.delete();
      end
    end else begin
      mIdle++;
      if (mIdle == TIMEOUT) begin
        mStale = 1;
        mRdy = 0;
        win.delete();
        mIdle = 0;
      end
    end
  endtask

  task automatic drive(bit r, bit v, int d);
    exp_t e;
    @(negedge CLK);
    RST = r;
    sampleValid = v;
    sampleIn = v ? 12'(d) : 12'($urandom);
    model_step(r, v, v ? d : 0);
    e.temp = mTemp;
    e.rdy = mRdy;
    e.stl = mStale;
    expq.push_back(e);
  endtask

  task automatic strobe(int d);
    drive(0, 1, d);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0);
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("digitalTemp", int'(digitalTemp), e.temp);
      chk("ready", int'(ready), int'(e.rdy));
      chk("stale", int'(stale), int'(e.stl));
    end
  end

  initial begin
    int mode;
    drive(1, 0, 0);
    drive(1, 0, 0);

    for (int i = 0; i < N; i++) strobe(1500);
    idle(2);
    for (int i = 0; i < N; i++) strobe(i);
    for (int i = 0; i < N; i++) strobe(4095);
    idle(TIMEOUT);
    idle(3);
    for (int i = 0; i < N; i++) strobe(2000);
    idle(TIMEOUT - 1);
    strobe(777);
    for (int i = 1; i < N; i++) strobe(100 * i);
    for (int i = 0; i < 5; i++) strobe(3000);
    drive(1, 0, 0);
    for (int i = 0; i < N; i++) strobe(1000);
    drive(1, 0, 0);
    for (int i = 0; i < 3; i++) strobe(4000);
    idle(TIMEOUT);
    for (int i = 0; i < N; i++) strobe(int'($urandom_range(0, 4095)));

    for (int b = 0; b < 250; b++) begin
      mode = int'($urandom_range(0, 9));
      if (mode == 0) begin
        idle(int'($urandom_range(TIMEOUT - 3, TIMEOUT + 40)));
      end else if (mode == 1) begin
        drive(1, 0, 0);
      end else begin
        for (int i = 0; i < 40; i++)
          drive(0, ($urandom_range(0, 2) != 0),
                int'($urandom_range(0, 4095)));
      end
    end
    idle(3);

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge CLK);
    #2;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
